// File: rtl/fb_sram_arbiter.sv
// Dual-bank frame buffer arbiter: capture writes into one bank of an external async
// SRAM while scan-out reads the other; banks swap on each capture frame pulse.
module fb_sram_arbiter #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8,
   parameter int FB_BYTES = 28800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap_req,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic [DATA_W-1:0] cap_data,
   input  logic              cap_frm,
   output logic              cap_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W:0]   sram_addr,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              wr_bank
);

   localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_ADDR,
      R_SAMP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W:0]     acc_addr;
   logic [DATA_W-1:0]   acc_data;
   logic                acc_oor;
   logic                rd_bank;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Strobes are decoded from state so an aborted access drops them on the reset edge.
   always_comb begin
      state_nxt  = state;
      cap_ack    = 1'b0;
      sram_ce_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_dq_oe = 1'b0;
      case (state)
         IDLE: begin
            if (cap_req)     state_nxt = W_SETUP;
            else if (rd_req) state_nxt = R_ADDR;
         end
         W_SETUP: begin
            sram_ce_n = 1'b0;
            state_nxt = W_PULSE;
         end
         W_PULSE: begin
            sram_ce_n  = 1'b0;
            sram_we_n  = acc_oor;
            sram_dq_oe = 1'b1;
            state_nxt  = W_HOLD;
         end
         W_HOLD: begin
            sram_ce_n  = 1'b0;
            sram_dq_oe = 1'b1;
            cap_ack    = 1'b1;
            state_nxt  = IDLE;
         end
         R_ADDR: begin
            sram_ce_n = 1'b0;
            sram_oe_n = acc_oor;
            state_nxt = R_SAMP;
         end
         R_SAMP: begin
            sram_ce_n = 1'b0;
            sram_oe_n = acc_oor;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sram_addr = acc_addr;
   assign sram_dq_o = acc_data;

   // The bank bit is captured with the address, so a swap never redirects a latched access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_addr <= '0;
         acc_data <= '0;
         acc_oor  <= 1'b0;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (state == IDLE) begin
            if (cap_req) begin
               acc_addr <= {wr_bank, cap_addr};
               acc_data <= cap_data;
               acc_oor  <= (cap_addr >= FB_LIMIT);
            end else if (rd_req) begin
               acc_addr <= {rd_bank, rd_addr};
               acc_oor  <= (rd_addr >= FB_LIMIT);
            end
         end
         if (state == R_SAMP) begin
            rd_data  <= acc_oor ? '0 : sram_dq_i;
            rd_valid <= 1'b1;
         end
         if (cap_frm) begin
            wr_bank <= ~wr_bank;
            rd_bank <= wr_bank;
         end
      end
   end

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Self-checking bench for fb_sram_arbiter: directed table, contention/abort sequences,
// and randomized traffic against a bank-aware memory model.
module tb_fb_sram_arbiter;

   localparam int ADDR_W   = 15;
   localparam int DATA_W   = 8;
   localparam int FB_BYTES = 28800;

   logic              clk;
   logic              rst_n;
   logic              cap_req;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;
   logic              cap_frm;
   logic              cap_ack;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [ADDR_W:0]   sram_addr;
   logic [DATA_W-1:0] sram_dq_o;
   logic              sram_dq_oe;
   logic [DATA_W-1:0] sram_dq_i;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic              wr_bank;

   fb_sram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_BYTES(FB_BYTES)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cap_req(cap_req), .cap_addr(cap_addr), .cap_data(cap_data),
      .cap_frm(cap_frm), .cap_ack(cap_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
      .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .wr_bank(wr_bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External SRAM contents and bus observations
   logic [7:0]  sram    [0:65535];
   logic [7:0]  ref_mem [0:65535];
   int          we_low_total, oe_low_total, overlap_total, gap_viol_total, since_oe;
   logic [15:0] last_addr;

   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 8'hEE;

   initial begin
      for (int i = 0; i < 65536; i++) sram[i] = 8'h5A;
      we_low_total   = 0;
      oe_low_total   = 0;
      overlap_total  = 0;
      gap_viol_total = 0;
      since_oe       = 100;
      last_addr      = '0;
      forever begin
         @(negedge clk);
         if (!sram_ce_n) last_addr = sram_addr;
         if (!sram_we_n) begin
            we_low_total++;
            if (since_oe < 2) gap_viol_total++;
            if (!sram_ce_n && sram_dq_oe) sram[sram_addr] = sram_dq_o;
         end
         if (sram_dq_oe && !sram_oe_n) overlap_total++;
         if (!sram_oe_n) begin
            oe_low_total++;
            since_oe = 0;
         end else if (since_oe < 100) begin
            since_oe++;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   int   checks;
   int   failures;
   logic m_wr;
   logic m_rd;

   typedef struct {
      bit          is_wr;
      bit          frm;
      logic [14:0] addr;
      logic [7:0]  data;
      logic        bank;
      int          strobe;
   } vec_t;

   vec_t vecs [9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_frame();
      cap_frm = 1'b1;
      @(posedge clk); #1;
      cap_frm = 1'b0;
      m_rd = m_wr;
      m_wr = ~m_wr;
      checkOutput("wr_bank_swap", 32'(wr_bank), 32'(m_wr));
   endtask

   task automatic do_write(input logic [14:0] addr, input logic [7:0] data,
                           output int lat, output int we_cnt);
      int we0;
      we0      = we_low_total;
      cap_addr = addr;
      cap_data = data;
      cap_req  = 1'b1;
      lat      = 99;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (cap_ack) begin
            lat = c;
            break;
         end
      end
      cap_req = 1'b0;
      we_cnt  = we_low_total - we0;
      if (int'(addr) < FB_BYTES) ref_mem[{m_wr, addr}] = data;
      @(posedge clk); #1;
      checkOutput("cap_ack_one_clk", 32'(cap_ack), 32'd0);
   endtask

   task automatic do_read(input logic [14:0] addr, output logic [7:0] data,
                          output int lat, output int oe_cnt);
      int oe0;
      oe0     = oe_low_total;
      rd_addr = addr;
      rd_req  = 1'b1;
      lat     = 99;
      data    = 8'hxx;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (rd_valid) begin
            lat  = c;
            data = rd_data;
            break;
         end
      end
      rd_req = 1'b0;
      oe_cnt = oe_low_total - oe0;
      @(posedge clk); #1;
      checkOutput("rd_valid_one_clk", 32'(rd_valid), 32'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      int         lat;
      int         cnt;
      logic [7:0] got;
      if (v.frm) pulse_frame();
      if (v.is_wr) begin
         do_write(v.addr, v.data, lat, cnt);
         checkOutput("wr_latency", 32'(lat), 32'd3);
         checkOutput("wr_bank_bit", 32'(last_addr[15]), 32'(v.bank));
         checkOutput("we_pulses", 32'(cnt), 32'(v.strobe));
         checkOutput("sram_content", 32'(sram[{v.bank, v.addr}]),
                     (v.strobe != 0) ? 32'(v.data) : 32'h5A);
      end else begin
         do_read(v.addr, got, lat, cnt);
         checkOutput("rd_latency", 32'(lat), 32'd3);
         checkOutput("rd_bank_bit", 32'(last_addr[15]), 32'(v.bank));
         checkOutput("oe_cycles", 32'(cnt), 32'(2 * v.strobe));
         checkOutput("rd_data", 32'(got), 32'(v.data));
      end
   endtask

   initial begin
      int          wr_t, rd_t, lat, cnt, ack_seen;
      logic [7:0]  got, exp_rd;
      logic [14:0] a;
      logic [7:0]  d;
      logic        old_bank, in_range;

      checks   = 0;
      failures = 0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h5A;

      //          is_wr frm  addr        data   bank  strobe
      vecs[0] = '{1'b1, 1'b0, 15'd5,     8'hA5, 1'b0, 1};
      vecs[1] = '{1'b0, 1'b1, 15'd5,     8'hA5, 1'b0, 1};
      vecs[2] = '{1'b1, 1'b0, 15'd28799, 8'h3C, 1'b1, 1};
      vecs[3] = '{1'b1, 1'b0, 15'd28800, 8'hFF, 1'b1, 0};
      vecs[4] = '{1'b0, 1'b1, 15'd28799, 8'h3C, 1'b1, 1};
      vecs[5] = '{1'b0, 1'b0, 15'd28800, 8'h00, 1'b1, 0};
      vecs[6] = '{1'b1, 1'b0, 15'd5,     8'h11, 1'b0, 1};
      vecs[7] = '{1'b0, 1'b0, 15'd5,     8'h5A, 1'b1, 1};
      vecs[8] = '{1'b0, 1'b1, 15'd5,     8'h11, 1'b0, 1};

      rst_n    = 1'b0;
      cap_req  = 1'b0;
      cap_addr = '0;
      cap_data = '0;
      cap_frm  = 1'b0;
      rd_req   = 1'b0;
      rd_addr  = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_cap_ack",  32'(cap_ack),    32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid),   32'd0);
      checkOutput("rst_rd_data",  32'(rd_data),    32'd0);
      checkOutput("rst_ce_n",     32'(sram_ce_n),  32'd1);
      checkOutput("rst_oe_n",     32'(sram_oe_n),  32'd1);
      checkOutput("rst_we_n",     32'(sram_we_n),  32'd1);
      checkOutput("rst_dq_oe",    32'(sram_dq_oe), 32'd0);
      checkOutput("rst_addr",     32'(sram_addr),  32'd0);
      checkOutput("rst_dq_o",     32'(sram_dq_o),  32'd0);
      checkOutput("rst_wr_bank",  32'(wr_bank),    32'd0);
      rst_n = 1'b1;
      m_wr  = 1'b0;
      m_rd  = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

      // Read accepted first, write requested one clk later
      rd_addr = 15'd5;
      rd_req  = 1'b1;
      @(posedge clk); #1;
      cap_addr = 15'd7;
      cap_data = 8'h77;
      cap_req  = 1'b1;
      wr_t = 99; rd_t = 99; got = 8'h00;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (rd_valid && rd_t == 99) begin
            rd_t   = c + 1;
            got    = rd_data;
            rd_req = 1'b0;
         end
         if (cap_ack) begin
            wr_t    = c;
            cap_req = 1'b0;
         end
         if (wr_t != 99 && rd_t != 99) break;
      end
      ref_mem[{m_wr, 15'd7}] = 8'h77;
      checkOutput("contend_rd_latency", 32'(rd_t), 32'd3);
      checkOutput("contend_rd_data", 32'(got), 32'(ref_mem[{m_rd, 15'd5}]));
      checkOutput("contend_ack_within_6", 32'(wr_t <= 6), 32'd1);
      checkOutput("contend_read_first", 32'(rd_t - 1 < wr_t), 32'd1);
      @(posedge clk); #1;

      // Simultaneous requests: write wins, read follows
      cap_addr = 15'd9;
      cap_data = 8'h88;
      cap_req  = 1'b1;
      rd_addr  = 15'd5;
      rd_req   = 1'b1;
      wr_t = 99; rd_t = 99; got = 8'h00;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (cap_ack && wr_t == 99) begin
            wr_t    = c;
            cap_req = 1'b0;
         end
         if (rd_valid) begin
            rd_t   = c;
            got    = rd_data;
            rd_req = 1'b0;
         end
         if (wr_t != 99 && rd_t != 99) break;
      end
      ref_mem[{m_wr, 15'd9}] = 8'h88;
      checkOutput("both_wr_latency", 32'(wr_t), 32'd3);
      checkOutput("both_rd_latency", 32'(rd_t), 32'd7);
      checkOutput("both_rd_data", 32'(got), 32'(ref_mem[{m_rd, 15'd5}]));
      @(posedge clk); #1;

      // Frame pulse coincident with the write latch, then reset mid-pulse
      old_bank = m_wr;
      cap_addr = 15'd100;
      cap_data = 8'h42;
      cap_req  = 1'b1;
      cap_frm  = 1'b1;
      @(posedge clk); #1;
      cap_frm = 1'b0;
      m_rd = m_wr;
      m_wr = ~m_wr;
      checkOutput("frm_latch_wr_bank", 32'(wr_bank), 32'(m_wr));
      checkOutput("frm_latch_old_bank", 32'(sram_addr[15]), 32'(old_bank));
      @(posedge clk); #1;
      checkOutput("abort_we_low_in_pulse", 32'(sram_we_n), 32'd0);
      rst_n   = 1'b0;
      cap_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
      checkOutput("abort_ce_n", 32'(sram_ce_n), 32'd1);
      checkOutput("abort_no_ack", 32'(cap_ack), 32'd0);
      checkOutput("abort_wr_bank", 32'(wr_bank), 32'd0);
      checkOutput("abort_old_bank_data", 32'(sram[{old_bank, 15'd100}]), 32'h42);
      checkOutput("abort_new_bank_clean", 32'(sram[{~old_bank, 15'd100}]), 32'h5A);
      ref_mem[{old_bank, 15'd100}] = 8'h42;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ack_seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cap_ack) ack_seen++;
      end
      checkOutput("abort_ack_after", 32'(ack_seen), 32'd0);
      m_wr = 1'b0;
      m_rd = 1'b1;

      // Randomized traffic against the bank/memory model
      for (int n = 0; n < 80; n++) begin
         int op, r;
         op = int'($urandom_range(0, 8));
         r  = int'($urandom_range(0, 9));
         if (r == 0)      a = 15'($urandom_range(28800, 32767));
         else if (r == 1) a = 15'd28799;
         else             a = 15'($urandom_range(0, 31));
         in_range = (int'(a) < FB_BYTES);
         if (op == 0) begin
            pulse_frame();
         end else if (op <= 4) begin
            d = 8'($urandom_range(0, 255));
            do_write(a, d, lat, cnt);
            checkOutput("rnd_wr_latency", 32'(lat), 32'd3);
            checkOutput("rnd_wr_bank", 32'(last_addr[15]), 32'(m_wr));
            checkOutput("rnd_we_pulses", 32'(cnt), in_range ? 32'd1 : 32'd0);
         end else begin
            exp_rd = in_range ? ref_mem[{m_rd, a}] : 8'h00;
            do_read(a, got, lat, cnt);
            checkOutput("rnd_rd_latency", 32'(lat), 32'd3);
            checkOutput("rnd_rd_bank", 32'(last_addr[15]), 32'(m_rd));
            checkOutput("rnd_rd_data", 32'(got), 32'(exp_rd));
         end
      end

      checkOutput("bus_overlap", 32'(overlap_total), 32'd0);
      checkOutput("read_write_gap", 32'(gap_viol_total), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
